// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants for the three-requester register-file write arbiter.
// Requester indices, the discarded zero register and pointer helpers live here.
package regfile_write_arbiter_pkg;

  localparam int NREQ     = 3;
  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_LINK = 2;
  localparam int ZERO_REG = 31;

  typedef logic [1:0]      ptr_t;
  typedef logic [NREQ-1:0] req_vec_t;

  // One-hot grant to requester index; an empty grant maps to index 0.
  function automatic ptr_t onehot_to_idx(input req_vec_t oh);
    ptr_t idx;
    idx = 2'd0;
    if (oh[REQ_LOAD]) idx = 2'd1;
    if (oh[REQ_LINK]) idx = 2'd2;
    return idx;
  endfunction

  // Pointer after serving requester idx: (idx + 1) mod 3.
  function automatic ptr_t next_ptr(input ptr_t idx);
    return (idx >= 2'd2) ? 2'd0 : ptr_t'(idx + 2'd1);
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Request/acknowledge and register-file write bus of the write arbiter.
// The arbiter uses the slave modport; the requester side uses master.
interface regfile_write_arbiter_if #(
  parameter int N = 64,
  parameter int A = 5
);
  logic [2:0]   req;
  logic [A-1:0] addr0;
  logic [A-1:0] addr1;
  logic [A-1:0] addr2;
  logic [N-1:0] data0;
  logic [N-1:0] data1;
  logic [N-1:0] data2;
  logic         hold;
  logic [2:0]   ack;
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [N-1:0] wr_data;

  modport master (
    output req, addr0, addr1, addr2, data0, data1, data2, hold,
    input  ack, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  req, addr0, addr1, addr2, data0, data1, data2, hold,
    output ack, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/regfile_write_arbiter_pick.sv
// Combinational three-way round-robin pick: priority runs ptr, ptr+1, ptr+2 mod 3.
// An out-of-range pointer value (3) is treated as 0.
module rr_pick3
  import regfile_write_arbiter_pkg::*;
(
  input  req_vec_t req_i,
  input  ptr_t     ptr_i,
  output req_vec_t gnt_o,
  output logic     valid_o
);

  ptr_t       base;
  logic [2:0] sum;
  ptr_t       idx;

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    sum     = '0;
    idx     = '0;
    base    = (ptr_i == 2'd3) ? 2'd0 : ptr_i;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, base} + 3'(k);
      idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter funnelling ALU, load and link writes into one register-file
// write port with one-cycle registered acknowledge and write outputs.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int N = 64,
  parameter int A = 5
) (
  input logic                   clock,
  input logic                   R,
  regfile_write_arbiter_if.slave bus
);

  logic [A-1:0] addr_arr [NREQ];
  logic [N-1:0] data_arr [NREQ];

  req_vec_t     ack_q, ack_d;
  logic         wr_en_q, wr_en_d;
  logic [A-1:0] wr_addr_q, wr_addr_d;
  logic [N-1:0] wr_data_q, wr_data_d;
  ptr_t         ptr_q, ptr_d;

  req_vec_t     req_eff;
  req_vec_t     gnt;
  logic         gnt_valid;
  ptr_t         gnt_idx;
  logic [A-1:0] sel_addr;
  logic [N-1:0] sel_data;

  assign addr_arr[REQ_ALU]  = bus.addr0;
  assign addr_arr[REQ_LOAD] = bus.addr1;
  assign addr_arr[REQ_LINK] = bus.addr2;
  assign data_arr[REQ_ALU]  = bus.data0;
  assign data_arr[REQ_LOAD] = bus.data1;
  assign data_arr[REQ_LINK] = bus.data2;

  // A requester whose ack is visible this cycle has not yet had a chance to drop req.
  assign req_eff = bus.req & ~ack_q & {NREQ{~bus.hold}};

  rr_pick3 u_pick (
    .req_i   (req_eff),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt),
    .valid_o (gnt_valid)
  );

  assign gnt_idx  = onehot_to_idx(gnt);
  assign sel_addr = addr_arr[gnt_idx];
  assign sel_data = data_arr[gnt_idx];

  always_comb begin
    ack_d     = gnt;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ptr_d     = ptr_q;
    if (gnt_valid) begin
      wr_en_d   = (sel_addr != A'(ZERO_REG));
      wr_addr_d = sel_addr;
      wr_data_d = sel_data;
      ptr_d     = next_ptr(gnt_idx);
    end
  end

  always_ff @(posedge clock or posedge R) begin
    if (R) begin
      ack_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ptr_q     <= 2'd0;
    end else begin
      ack_q     <= ack_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.ack     = ack_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The module SHALL have parameter N, default 64, giving the data width in bits.
REQ-002 The module SHALL have parameter A, default 5, giving the register address width.
REQ-003 The module SHALL have port clock, input, 1, positive-edge clock.
REQ-004 The module SHALL have port R, input, 1, asynchronous active-high reset.
REQ-005 The module SHALL have port req, input, 3, per-requester write request (bit0 ALU, bit1 load, bit2 link).
REQ-006 The module SHALL have port addr0/addr1/addr2, input, A each, destination register of each requester.
REQ-007 The module SHALL have port data0/data1/data2, input, N each, write data of each requester.
REQ-008 The module SHALL have port hold, input, 1, which blocks grants while high.
REQ-009 The module SHALL have port ack, output, 3, one-cycle registered acknowledge per requester.
REQ-010 The module SHALL have port wr_en, output, 1, registered register-file write enable.
REQ-011 The module SHALL have port wr_addr, output, A, registered write address.
REQ-012 The module SHALL have port wr_data, output, N, registered write data.

Function
REQ-013 The module SHALL grant at most one requester per cycle, chosen from req bits that are high while hold is low.
REQ-014 The module SHALL arbitrate round-robin: a 2-bit pointer names the highest-priority requester, and priority descends pointer, pointer+1, pointer+2, all mod 3.
REQ-015 After a grant to requester i, the pointer SHALL become (i+1) mod 3 on the same clock edge; with no grant, the pointer SHALL hold.
REQ-016 On the edge that grants requester i, the module SHALL register ack[i]=1 (other ack bits 0), wr_addr=addr_i and wr_data=data_i, giving 1-cycle latency.
REQ-017 wr_en SHALL be 1 for the granted cycle, except that it SHALL be 0 when addr_i equals the zero register (all ones, 31); ack[i] SHALL still be 1.
REQ-018 With no grant, ack SHALL be 0 and wr_en SHALL be 0, while wr_addr and wr_data hold their previous values.
REQ-019 Handshake: a requester SHALL hold req, addr and data stable until it sees ack. It SHALL drop req in the cycle ack is seen unless it has a new write.
REQ-020 The module SHALL NOT issue a second grant to a requester in the cycle its ack is high; req[i] is masked by ack[i] for that cycle.
REQ-021 When hold is high, the module SHALL issue no grant, register ack=0 and wr_en=0, and keep the pointer unchanged; pending requests SHALL remain pending.
REQ-022 If all three requests are continuously high, grants SHALL rotate strictly, so no requester waits more than 2 cycles behind others. With masking (REQ-020), the ack sequence is 0,1,2,0...
REQ-023 The pointer SHALL wrap from 2 to 0.

Reset
REQ-024 While R=1, asynchronously: ack=0, wr_en=0, wr_addr=0, wr_data=0, pointer=0.
REQ-025 Reset mid-operation SHALL discard any in-flight grant. Requesters SHALL re-present unacked writes after R deasserts, and the first grant after reset SHALL follow pointer=0.
REQ-026 R SHALL take priority over all other inputs, including the clock edge in which it asserts.

Structure
REQ-027 A shared package SHALL hold NREQ=3, the requester index constants (REQ_ALU=0, REQ_LOAD=1, REQ_LINK=2) and ZERO_REG=31.
REQ-028 One combinational sub-module, rr_pick3, SHALL take a 3-bit request and a 2-bit pointer and return a one-hot grant plus a valid flag. All state SHALL reside in regfile_write_arbiter.

Verification
REQ-029 Reset: assert R mid-cycle with req=3'b111 -> ack=0, wr_en=0, wr_addr=0, wr_data=0 immediately; the first post-reset grant is to requester 0.
REQ-030 Single request: req=3'b010, addr1=7, data1=64'hDEAD_BEEF -> next edge: ack=3'b010, wr_en=1, wr_addr=7, wr_data=64'hDEAD_BEEF; the following cycle wr_en=0.
REQ-031 Fairness: req=3'b111 held, each requester re-asserting after ack -> ack sequence 001,010,100,001 over 4 grants, with wr_addr matching each requester.
REQ-032 Zero register: req=3'b001, addr0=31 -> ack=3'b001 and wr_en=0.
REQ-033 Hold: req=3'b101 with hold=1 for 3 cycles -> ack=0 and wr_en=0 throughout; after hold drops, grant goes to requester 0, then requester 2.
REQ-034 Pointer wrap: grant requester 2 alone, then req=3'b011 -> grant goes to requester 0 (pointer=0), then requester 1.
